// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter in front of an async-FIFO write port.
// A grant is held until the winner's last beat is written or MAX_PKT beats pass.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_PKT    = 16
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_in,
    input  logic                          full,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic                          busy,
    output logic                          err_overlen
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_PKT) + 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] win;
    logic [IW-1:0] next_ptr;
    logic [CW-1:0] beat_cnt;
    logic          acked;
    logic          last_w;
    logic          at_max;
    logic          release_pkt;

    // Descending scan so the lowest rotation offset from rr_ptr wins.
    always_comb begin
        int            idx;
        logic [IW-1:0] sel;
        win = '0;
        idx = 0;
        sel = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = IW'(idx);
            if (req[sel]) begin
                win = sel;
            end
        end
    end

    always_comb begin
        wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                wdata = wdata_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // gnt is zero outside LOCKED, so ack needs no extra state term.
    assign ack         = gnt & req & {NUM_REQ{~full}};
    assign acked       = |ack;
    assign w_en        = acked;
    assign last_w      = |(ack & last);
    assign at_max      = (beat_cnt == CW'(MAX_PKT - 1));
    assign release_pkt = acked & (last_w | at_max);
    assign next_ptr    = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state       <= IDLE;
            gnt         <= '0;
            gnt_idx     <= '0;
            rr_ptr      <= '0;
            beat_cnt    <= '0;
            busy        <= 1'b0;
            err_overlen <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= LOCKED;
                        gnt      <= NUM_REQ'(1) << win;
                        gnt_idx  <= win;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (release_pkt) begin
                        state    <= IDLE;
                        gnt      <= '0;
                        beat_cnt <= '0;
                        busy     <= 1'b0;
                        rr_ptr   <= next_ptr;
                        if (!last_w) begin
                            err_overlen <= 1'b1;
                        end
                    end else if (acked) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios then random traffic
// against a packet-level reference model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MP = 4;

    logic            wclk = 1'b0;
    logic            wrst;
    logic [N-1:0]    req;
    logic [N-1:0]    last;
    logic [N*DW-1:0] wdata_in;
    logic            full;
    logic [N-1:0]    ack;
    logic [N-1:0]    gnt;
    logic            w_en;
    logic [DW-1:0]   wdata;
    logic            busy;
    logic            err_overlen;

    fifo_wr_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(DW),
        .MAX_PKT   (MP)
    ) dut (
        .wclk       (wclk),
        .wrst       (wrst),
        .req        (req),
        .last       (last),
        .wdata_in   (wdata_in),
        .full       (full),
        .ack        (ack),
        .gnt        (gnt),
        .w_en       (w_en),
        .wdata      (wdata),
        .busy       (busy),
        .err_overlen(err_overlen)
    );

    always #5 wclk = ~wclk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [N-1:0]  ack;
        logic [DW-1:0] data;
    } beat_t;

    beat_t exp_q[$];

    int m_owner = -1;
    int m_beats = 0;
    int m_ptr   = 0;
    bit m_err   = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: who owns the port, beats sent, rotation start.
    task automatic model_eval();
        logic [N-1:0] eg;
        eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        check("gnt", 32'(gnt), 32'(eg));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("err_overlen", 32'(err_overlen), 32'(m_err));
        if (m_owner < 0)
            check("wdata_idle", 32'(wdata), 32'(0));
        else
            check("wdata_mux", 32'(wdata), 32'(wdata_in[m_owner*DW +: DW]));
        if (m_owner >= 0) begin
            if (req[m_owner] && !full) begin
                exp_q.push_back('{eg, wdata_in[m_owner*DW +: DW]});
                m_beats++;
                if (last[m_owner] || m_beats == MP) begin
                    if (!last[m_owner]) m_err = 1'b1;
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end
        end else if (req != '0) begin
            for (int k = 0; k < N; k++) begin
                if (req[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    break;
                end
            end
            m_beats = 0;
        end
        if (wrst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_beats = 0;
            m_err   = 1'b0;
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l,
                        input logic f, input logic rs);
        @(posedge wclk);
        #1;
        req      = r;
        last     = l;
        full     = f;
        wrst     = rs;
        wdata_in = $urandom;
        @(negedge wclk);
        model_eval();
    endtask

    initial begin : monitor
        beat_t e;
        forever begin
            @(negedge wclk);
            #2;
            if (w_en && full) check("w_en_while_full", 32'(w_en), 32'(0));
            if (w_en || ack != '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: ack=%b wdata=%0h expected no write",
                             ack, wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("ack", 32'(ack), 32'(e.ack));
                    check("wdata", 32'(wdata), 32'(e.data));
                    check("w_en", 32'(w_en), 32'(1));
                end
            end
        end
    end

    initial begin : stim
        wrst     = 1'b1;
        req      = '0;
        last     = '0;
        full     = 1'b0;
        wdata_in = '0;
        repeat (2) @(posedge wclk);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        check("reset_gnt", 32'(gnt), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));

        // Single-beat packet from requester 0
        step(4'b0001, 4'b0001, 1'b0, 1'b0);
        step(4'b0001, 4'b0001, 1'b0, 1'b0);
        check("t1_gnt", 32'(gnt), 32'(4'b0001));
        check("t1_ack", 32'(ack), 32'(4'b0001));
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        check("t1_released", 32'(gnt), 32'(0));

        // All requesting with last: strict rotation
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        repeat (10) step(4'b1111, 4'b1111, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);

        // Three-beat packet, requester 1 waiting
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        step(4'b0011, 4'b0000, 1'b0, 1'b0);
        step(4'b0011, 4'b0000, 1'b0, 1'b0);
        step(4'b0011, 4'b0000, 1'b0, 1'b0);
        step(4'b0011, 4'b0001, 1'b0, 1'b0);
        step(4'b0010, 4'b0000, 1'b0, 1'b0);
        step(4'b0010, 4'b0010, 1'b0, 1'b0);
        check("t3_gnt1", 32'(gnt), 32'(4'b0010));

        // Back-pressure while locked on requester 2
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        step(4'b0100, 4'b0000, 1'b0, 1'b0);
        repeat (5) begin
            step(4'b0100, 4'b0000, 1'b1, 1'b0);
            check("t4_ack_full", 32'(ack), 32'(0));
        end
        step(4'b0100, 4'b0100, 1'b0, 1'b0);
        check("t4_ack_resume", 32'(ack), 32'(4'b0100));

        // Overlength packet forces release and sets the sticky error
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        repeat (6) step(4'b0001, 4'b0000, 1'b0, 1'b0);
        repeat (3) step(4'b0000, 4'b0000, 1'b0, 1'b0);
        check("t5_err_sticky", 32'(err_overlen), 32'(1));

        // Reset mid-packet
        step(4'b0001, 4'b0000, 1'b0, 1'b0);
        step(4'b0001, 4'b0000, 1'b0, 1'b0);
        step(4'b0001, 4'b0000, 1'b0, 1'b0);
        step(4'b0001, 4'b0000, 1'b0, 1'b1);
        step(4'b0010, 4'b0010, 1'b0, 1'b0);
        check("t6_gnt_cleared", 32'(gnt), 32'(0));
        check("t6_err_cleared", 32'(err_overlen), 32'(0));
        step(4'b0010, 4'b0010, 1'b0, 1'b0);
        check("t6_gnt1", 32'(gnt), 32'(4'b0010));

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            step(N'($urandom),
                 N'($urandom & $urandom),
                 ($urandom_range(3) == 0),
                 ($urandom_range(199) == 0));
        end

        repeat (3) step(4'b0000, 4'b0000, 1'b0, 1'b0);
        #3;
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
